// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared constants for the multicycle MIPS control unit.
//   - opcode / funct values decoded from the instruction register
//   - 4-bit FSM state encodings (all 16 codes are used)
//   - ALU op, PC source, register destination, writeback mux and trap codes
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_JAL    = 4'd13;
    localparam logic [3:0] S_JR     = 4'd14;
    localparam logic [3:0] S_TRAP   = 4'd15;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // States that issue a memory request and may stall on mem_ready.
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_waitcnt.sv
// mips_mc_waitcnt: per-access wait counter and timeout detector.
//   clock, reset : rising-edge clock, async active-low reset
//   active       : FSM is in a memory-access state
//   mem_ready    : memory completes the access this cycle
//   timeout_hit  : last permitted wait cycle expired without ready
module mips_mc_waitcnt #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout_hit
);
    localparam int              LIMIT_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0] LIMIT  = LIMIT_I[TMO_W-1:0];

    logic [TMO_W-1:0] cnt;

    // Every access state is left on the ready cycle, and the counter is held
    // at zero outside access states, so each new access starts from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!active || mem_ready)
            cnt <= '0;
        else
            cnt <= cnt + TMO_W'(1);
    end

    // Ready in the same cycle wins over the timeout.
    assign timeout_hit = (MEM_TIMEOUT != 0) && active && !mem_ready && (cnt == LIMIT);

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: Moore FSM control unit for the multicycle MIPS datapath.
//   clock, reset        : rising-edge clock, async active-low reset
//   opcode, funct, zero : IR fields and ALU zero flag
//   mem_ready           : memory handshake completion
//   mem_req/mem_we/i_or_d, ir_write, pc_write, pc_source, alu_src_a/b,
//   alu_op, reg_write, reg_dst, mem_to_reg : datapath controls
//   halt, trap_cause    : sticky trap status
//   instr_count         : retired instruction counter (wraps)
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             halt,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);
    logic [3:0] state, state_nx;
    logic [1:0] cause_nx;
    logic       timeout_hit;

    mips_mc_waitcnt #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_waitcnt (
        .clock       (clock),
        .reset       (reset),
        .active      (is_mem_state(state)),
        .mem_ready   (mem_ready),
        .timeout_hit (timeout_hit)
    );

    always_comb begin
        state_nx = state;
        cause_nx = TRAP_NONE;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (mem_ready)
                    state_nx = (state == S_FETCH) ? S_DECODE :
                               (state == S_MEMRD) ? S_MEMWB  : S_FETCH;
                else if (timeout_hit) begin
                    state_nx = S_TRAP;
                    cause_nx = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_nx = (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_LW, OP_SW:   state_nx = S_MEMADR;
                    OP_BEQ, OP_BNE: state_nx = S_BRANCH;
                    OP_ADDI:        state_nx = S_IEXEC;
                    OP_J:           state_nx = S_JUMP;
                    OP_JAL:         state_nx = S_JAL;
                    default: begin
                        state_nx = S_TRAP;
                        cause_nx = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: state_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_EXEC:   state_nx = S_RWB;
            S_IEXEC:  state_nx = S_IWB;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_FETCH;   // MEMWB, RWB, IWB, BRANCH, JUMP, JAL, JR
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            trap_cause  <= TRAP_NONE;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == S_TRAP && state != S_TRAP)
                trap_cause <= cause_nx;
            // The first fetch after reset does not retire anything.
            if (state_nx == S_FETCH && state != S_FETCH && state != S_IDLE)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_OP_ADD;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALU;
        halt       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = REGDST_RD;
            end
            S_IWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                // PC still holds PC+4 here, so it is the link value.
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_RS;
            end
            S_TRAP: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed bench with a scoreboard queue. Each stimulus
// cycle pushes the expected control vector; a negedge monitor pops and checks.
module tb_mips_mc_control;

    typedef struct packed {
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       halt;
        logic [1:0] trap_cause;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        int unsigned cnt;
        string       nm;
    } exp_t;

    logic        clock = 1'b0, reset = 1'b0;
    logic [5:0]  opcode = '0, funct = '0;
    logic        zero = 1'b0, mem_ready = 1'b0;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a;
    logic        reg_write, halt;
    logic [1:0]  pc_source, alu_src_b, reg_dst, mem_to_reg, trap_cause;
    logic [2:0]  alu_op;
    logic [31:0] instr_count;

    int total = 0, bad = 0;
    exp_t q[$];

    mips_mc_control #(.CNT_W(32), .MEM_TIMEOUT(4), .TMO_W(3)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .halt(halt), .trap_cause(trap_cause),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    function automatic ctl_t actual();
        return '{mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source, alu_src_a,
                 alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halt, trap_cause};
    endfunction

    // Expected vectors, written out from the state output table.
    function automatic ctl_t e_idle();              ctl_t c = '0; return c; endfunction
    function automatic ctl_t e_fetch(input logic r);
        ctl_t c = '0; c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = r; c.pc_write = r; return c;
    endfunction
    function automatic ctl_t e_decode(); ctl_t c = '0; c.alu_src_b = 2'b11; return c; endfunction
    function automatic ctl_t e_aimm();   ctl_t c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; return c; endfunction
    function automatic ctl_t e_memrd();  ctl_t c = '0; c.mem_req = 1; c.i_or_d = 1; return c; endfunction
    function automatic ctl_t e_memwr();  ctl_t c = '0; c.mem_req = 1; c.i_or_d = 1; c.mem_we = 1; return c; endfunction
    function automatic ctl_t e_memwb();  ctl_t c = '0; c.reg_write = 1; c.mem_to_reg = 2'b01; return c; endfunction
    function automatic ctl_t e_exec();   ctl_t c = '0; c.alu_src_a = 1; c.alu_op = 3'b010; return c; endfunction
    function automatic ctl_t e_rwb();    ctl_t c = '0; c.reg_write = 1; c.reg_dst = 2'b01; return c; endfunction
    function automatic ctl_t e_iwb();    ctl_t c = '0; c.reg_write = 1; return c; endfunction
    function automatic ctl_t e_branch(input logic pw);
        ctl_t c = '0; c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_source = 2'b01; c.pc_write = pw; return c;
    endfunction
    function automatic ctl_t e_jump();   ctl_t c = '0; c.pc_write = 1; c.pc_source = 2'b10; return c; endfunction
    function automatic ctl_t e_jal();
        ctl_t c = '0; c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1;
        c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; return c;
    endfunction
    function automatic ctl_t e_jr();     ctl_t c = '0; c.pc_write = 1; c.pc_source = 2'b11; return c; endfunction
    function automatic ctl_t e_trap(input logic [1:0] cause);
        ctl_t c = '0; c.halt = 1; c.trap_cause = cause; return c;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show in it.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic rdy, input ctl_t c, input int unsigned cnt, input string nm);
        exp_t e;
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        e.c = c; e.cnt = cnt; e.nm = nm;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (actual() !== e.c || instr_count !== e.cnt) begin
                bad++;
                $display("FAIL %s: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d",
                         e.nm, actual(), instr_count, e.c, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock); #1;
        step(6'h00, 6'h20, 0, 1, e_idle(), 0, "reset_idle");
        reset = 1'b1;
        step(6'h00, 6'h20, 0, 1, e_idle(), 0, "idle_after_release");

        // R-type add
        step(6'h00, 6'h20, 0, 1, e_fetch(1), 0, "rtype_fetch");
        step(6'h00, 6'h20, 0, 1, e_decode(), 0, "rtype_decode");
        step(6'h00, 6'h20, 0, 1, e_exec(),   0, "rtype_exec");
        step(6'h00, 6'h20, 0, 1, e_rwb(),    0, "rtype_rwb");

        // lw with three stall cycles in MEMRD
        step(6'h23, 6'h00, 0, 1, e_fetch(1), 1, "lw_fetch");
        step(6'h23, 6'h00, 0, 1, e_decode(), 1, "lw_decode");
        step(6'h23, 6'h00, 0, 1, e_aimm(),   1, "lw_memadr");
        for (int i = 0; i < 3; i++)
            step(6'h23, 6'h00, 0, 0, e_memrd(), 1, "lw_memrd_stall");
        step(6'h23, 6'h00, 0, 1, e_memrd(), 1, "lw_memrd_ready");
        step(6'h23, 6'h00, 0, 1, e_memwb(), 1, "lw_memwb");

        // beq taken, bne not taken (zero=1 both)
        step(6'h04, 6'h00, 1, 1, e_fetch(1),   2, "beq_fetch");
        step(6'h04, 6'h00, 1, 1, e_decode(),   2, "beq_decode");
        step(6'h04, 6'h00, 1, 1, e_branch(1),  2, "beq_branch");
        step(6'h05, 6'h00, 1, 1, e_fetch(1),   3, "bne_fetch");
        step(6'h05, 6'h00, 1, 1, e_decode(),   3, "bne_decode");
        step(6'h05, 6'h00, 1, 1, e_branch(0),  3, "bne_branch");

        // addi, j, jal, jr
        step(6'h08, 6'h00, 0, 1, e_fetch(1), 4, "addi_fetch");
        step(6'h08, 6'h00, 0, 1, e_decode(), 4, "addi_decode");
        step(6'h08, 6'h00, 0, 1, e_aimm(),   4, "addi_iexec");
        step(6'h08, 6'h00, 0, 1, e_iwb(),    4, "addi_iwb");
        step(6'h02, 6'h00, 0, 1, e_fetch(1), 5, "j_fetch");
        step(6'h02, 6'h00, 0, 1, e_decode(), 5, "j_decode");
        step(6'h02, 6'h00, 0, 1, e_jump(),   5, "j_jump");
        step(6'h03, 6'h00, 0, 1, e_fetch(1), 6, "jal_fetch");
        step(6'h03, 6'h00, 0, 1, e_decode(), 6, "jal_decode");
        step(6'h03, 6'h00, 0, 1, e_jal(),    6, "jal_jal");
        step(6'h00, 6'h08, 0, 1, e_fetch(1), 7, "jr_fetch");
        step(6'h00, 6'h08, 0, 1, e_decode(), 7, "jr_decode");
        step(6'h00, 6'h08, 0, 1, e_jr(),     7, "jr_jr");

        // Fetch ready arrives on the last permitted cycle: no trap. Then sw.
        for (int i = 0; i < 3; i++)
            step(6'h2B, 6'h00, 0, 0, e_fetch(0), 8, "sw_fetch_stall");
        step(6'h2B, 6'h00, 0, 1, e_fetch(1), 8, "sw_fetch_late_ready");
        step(6'h2B, 6'h00, 0, 1, e_decode(), 8, "sw_decode");
        step(6'h2B, 6'h00, 0, 1, e_aimm(),   8, "sw_memadr");
        step(6'h2B, 6'h00, 0, 1, e_memwr(),  8, "sw_memwr");

        // Fetch timeout after 4 cycles without ready
        for (int i = 0; i < 4; i++)
            step(6'h00, 6'h20, 0, 0, e_fetch(0), 9, "tmo_fetch_wait");
        step(6'h00, 6'h20, 0, 1, e_trap(2'b10), 9, "tmo_trap");
        step(6'h00, 6'h20, 0, 1, e_trap(2'b10), 9, "tmo_trap_sticky");

        // Illegal opcode
        reset = 1'b0;
        step(6'h3F, 6'h00, 0, 1, e_idle(), 0, "reset_clears_trap");
        reset = 1'b1;
        step(6'h3F, 6'h00, 0, 1, e_idle(),      0, "ill_idle");
        step(6'h3F, 6'h00, 0, 1, e_fetch(1),    0, "ill_fetch");
        step(6'h3F, 6'h00, 0, 1, e_decode(),    0, "ill_decode");
        step(6'h3F, 6'h00, 0, 1, e_trap(2'b01), 0, "ill_trap");
        step(6'h3F, 6'h00, 0, 1, e_trap(2'b01), 0, "ill_trap_sticky");

        // Async reset in the middle of a stalled store
        reset = 1'b0;
        step(6'h00, 6'h20, 0, 1, e_idle(), 0, "reset2_idle");
        reset = 1'b1;
        step(6'h00, 6'h20, 0, 1, e_idle(),   0, "r2_idle");
        step(6'h00, 6'h20, 0, 1, e_fetch(1), 0, "r2_fetch");
        step(6'h00, 6'h20, 0, 1, e_decode(), 0, "r2_decode");
        step(6'h00, 6'h20, 0, 1, e_exec(),   0, "r2_exec");
        step(6'h00, 6'h20, 0, 1, e_rwb(),    0, "r2_rwb");
        step(6'h2B, 6'h00, 0, 1, e_fetch(1), 1, "r2_sw_fetch");
        step(6'h2B, 6'h00, 0, 1, e_decode(), 1, "r2_sw_decode");
        step(6'h2B, 6'h00, 0, 1, e_aimm(),   1, "r2_sw_memadr");
        step(6'h2B, 6'h00, 0, 0, e_memwr(),  1, "r2_sw_memwr_stall");
        // Still in MEMWR with mem_req high; pull reset between edges.
        #1 reset = 1'b0;
        #1;
        total++;
        if (actual() !== ctl_t'(0) || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: got ctl=%h cnt=%0d, expected ctl=0 cnt=0",
                     actual(), instr_count);
        end

        @(posedge clock); #1;
        @(posedge clock); #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational control and PC-select logic.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Stalls on a req/ready memory handshake and traps on illegal opcodes or memory timeouts.
- Sits between the instruction register (opcode/funct) and the shared-memory multicycle datapath; counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).
- MEM_TIMEOUT, 16, max wait cycles per memory access before trap; 0 disables timeout.
- TMO_W, 5, width of wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (1) / read (0); valid only with mem_req
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  load PC (already qualified with zero for branches)
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (jr)
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  3  000 add, 001 sub, 010 decode funct
- reg_write  out  1  regfile write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (jal link)
- halt  out  1  trapped; sticky until reset
- trap_cause  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (reset=0, async): state IDLE; wait counter, instr_count, trap_cause = 0. All outputs are 0 in IDLE.
- IDLE -> FETCH on the first clock with reset=1.
- Outputs are a pure function of state, except pc_write in BRANCH and the FETCH ready-gated strobes.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; the FSM stays in FETCH until then.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Dispatch on opcode:
  - 0x00 with funct 0x08 -> JR
  - 0x00 other -> EXEC
  - 0x23/0x2B -> MEMADR
  - 0x04/0x05 -> BRANCH
  - 0x08 -> IEXEC
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - anything else -> TRAP, cause 01
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000 -> MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, i_or_d=1, mem_we=0; stays until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEMWR: mem_req=1, i_or_d=1, mem_we=1; stays until mem_ready, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=000 -> IWB.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01.
  - pc_write = zero for beq, ~zero for bne -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH.
  - The PC register still holds PC+4 in this cycle.
- JR: pc_write=1, pc_source=11 -> FETCH.
- TRAP: halt=1, all other outputs 0; absorbing until reset.
- Wait counter:
  - Cleared on every entry into FETCH, MEMRD or MEMWR.
  - Increments each cycle in those states while mem_ready=0.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 with mem_ready=0 -> TRAP, cause 10.
  - If mem_ready=1 in that same cycle, ready wins and no trap occurs.
- instr_count: +1 on every transition into FETCH from a state other than IDLE. Wraps to 0.
- trap_cause: written once on entry to TRAP; held until reset.
- Reset asserted mid-access: immediate IDLE; mem_req drops asynchronously.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL, FN_JR)
  - 4-bit state encodings
  - ALU_OP_*, PCSRC_*, REGDST_*, M2R_*, TRAP_* codes
- One sub-module, mips_mc_waitcnt: wait counter plus timeout comparator, parameterised by MEM_TIMEOUT/TMO_W. Outputs timeout_hit.

Test Plan:
- Release reset, opcode 0x00/funct 0x20, mem_ready=1 always -> FETCH, DECODE, EXEC, RWB, back to FETCH. instr_count=1 after 4 cycles; reg_write=1 with reg_dst=01 in RWB.
- lw (0x23) with mem_ready held low for 3 cycles in MEMRD -> state holds, mem_req=1 and i_or_d=1 throughout. MEMWB follows the ready cycle; total 5 + 3 cycles.
- beq with zero=1, then bne with zero=1 -> pc_write=1 in BRANCH for beq, 0 for bne; pc_source=01 in both.
- jal (0x03) -> JAL cycle shows pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 cycles; halt=1, trap_cause=10. With mem_ready=1 on the 4th cycle, no trap.
- opcode 0x3F in DECODE -> TRAP, cause 01. Drive reset=0 asynchronously mid-MEMWR -> all outputs 0 immediately and instr_count=0.
